// File: rtl/cordic_post_fp_pack.sv
// CORDIC back end: applies quadrant signs, optionally clamps to 1.0, and packs
// the Q2.FRAC cos/sin pair into IEEE-754 single precision over a 2-stage pipeline.
module cordic_post_fp_pack #(
  parameter int W     = 24,
  parameter int FRAC  = W - 2,
  parameter int CLAMP = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] cos_fix,
  input  logic signed [W-1:0] sin_fix,
  input  logic                cos_neg,
  input  logic                sin_neg,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         cos_fp,
  output logic [31:0]         sin_fp,
  output logic                clamped
);

  localparam logic [W-1:0] ONE = W'(1) << FRAC;

  // Returns {clamp_bit, magnitude}; the most negative input maps cleanly to 2^(W-1).
  function automatic logic [W:0] abs_clamp(input logic signed [W-1:0] fix);
    logic [W-1:0] u;
    logic [W-1:0] mag;
    logic         clp;
    u   = fix;
    mag = u[W-1] ? (~u + W'(1)) : u;
    clp = 1'b0;
    if (CLAMP != 0 && mag > ONE) begin
      mag = ONE;
      clp = 1'b1;
    end
    return {clp, mag};
  endfunction

  // Normalise, then round to nearest even; a zero magnitude always yields +0.
  function automatic logic [31:0] to_fp(input logic sgn, input logic [W-1:0] mag);
    int            p;
    int            e;
    logic [W-1:0]  norm;
    logic [W+22:0] ext;
    logic [22:0]   mant;
    logic [23:0]   mant_r;
    logic          guard;
    logic          sticky;
    logic [31:0]   res;
    p = 0;
    for (int i = 0; i < W; i++) begin
      if (mag[i]) p = i;
    end
    norm   = mag << (W - 1 - p);
    ext    = {norm[W-2:0], 24'd0};
    mant   = ext[W+22 -: 23];
    guard  = ext[W-1];
    sticky = |ext[W-2:0];
    mant_r = {1'b0, mant} + 24'(guard & (sticky | mant[0]));
    e      = 127 + p - FRAC + int'(mant_r[23]);
    if (!norm[W-1]) res = 32'h0000_0000;
    else            res = {sgn, e[7:0], mant_r[22:0]};
    return res;
  endfunction

  logic          vld_p1_q, vld_p1_d;
  logic          vld_p2_q, vld_p2_d;
  logic          s1_adv;
  logic          in_xfer;
  logic [W:0]    cos_ac, sin_ac;
  logic          cos_sgn_p1_q, sin_sgn_p1_q;
  logic          cos_clp_p1_q, sin_clp_p1_q;
  logic [W-1:0]  cos_mag_p1_q, sin_mag_p1_q;
  logic [31:0]   cos_fp_p2_q, sin_fp_p2_q;
  logic          clp_p2_q;

  assign s1_adv   = vld_p1_q & (~vld_p2_q | out_ready);
  assign in_ready = ~vld_p1_q | s1_adv;
  assign in_xfer  = in_valid & in_ready;
  assign cos_ac   = abs_clamp(cos_fix);
  assign sin_ac   = abs_clamp(sin_fix);

  always_comb begin
    vld_p1_d = vld_p1_q;
    if (in_xfer)     vld_p1_d = 1'b1;
    else if (s1_adv) vld_p1_d = 1'b0;
    vld_p2_d = vld_p2_q;
    if (s1_adv)         vld_p2_d = 1'b1;
    else if (out_ready) vld_p2_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  // ---- stage 1: sign, magnitude, clamp ----
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      cos_sgn_p1_q <= cos_fix[W-1] ^ cos_neg;
      sin_sgn_p1_q <= sin_fix[W-1] ^ sin_neg;
      cos_clp_p1_q <= cos_ac[W];
      sin_clp_p1_q <= sin_ac[W];
      cos_mag_p1_q <= cos_ac[W-1:0];
      sin_mag_p1_q <= sin_ac[W-1:0];
    end
  end

  // ---- stage 2: float packing; outputs read zero out of reset ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cos_fp_p2_q <= 32'h0;
      sin_fp_p2_q <= 32'h0;
      clp_p2_q    <= 1'b0;
    end else if (s1_adv) begin
      cos_fp_p2_q <= to_fp(cos_sgn_p1_q, cos_mag_p1_q);
      sin_fp_p2_q <= to_fp(sin_sgn_p1_q, sin_mag_p1_q);
      clp_p2_q    <= cos_clp_p1_q | sin_clp_p1_q;
    end
  end

  assign out_valid = vld_p2_q;
  assign cos_fp    = cos_fp_p2_q;
  assign sin_fp    = sin_fp_p2_q;
  assign clamped   = clp_p2_q;

endmodule

// File: tb/tb_cordic_post_fp_pack.sv
// Directed bench: default build (clamp on), a clamp-off build and a 32-bit Q2.30
// build for rounding, checked against hand-computed IEEE-754 encodings.
module tb_cordic_post_fp_pack;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic               a_iv, a_ir, a_cn, a_sn, a_ov, a_or, a_cl;
  logic signed [23:0] a_cf, a_sf;
  logic [31:0]        a_cfp, a_sfp;
  logic               b_iv, b_ir, b_cn, b_sn, b_ov, b_or, b_cl;
  logic signed [23:0] b_cf, b_sf;
  logic [31:0]        b_cfp, b_sfp;
  logic               c_iv, c_ir, c_cn, c_sn, c_ov, c_or, c_cl;
  logic signed [31:0] c_cf, c_sf;
  logic [31:0]        c_cfp, c_sfp;

  int checks = 0;
  int errors = 0;

  cordic_post_fp_pack #(.W(24), .FRAC(22), .CLAMP(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .cos_fix(a_cf), .sin_fix(a_sf),
    .cos_neg(a_cn), .sin_neg(a_sn), .out_valid(a_ov), .out_ready(a_or),
    .cos_fp(a_cfp), .sin_fp(a_sfp), .clamped(a_cl));

  cordic_post_fp_pack #(.W(24), .FRAC(22), .CLAMP(0)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .cos_fix(b_cf), .sin_fix(b_sf),
    .cos_neg(b_cn), .sin_neg(b_sn), .out_valid(b_ov), .out_ready(b_or),
    .cos_fp(b_cfp), .sin_fp(b_sfp), .clamped(b_cl));

  cordic_post_fp_pack #(.W(32), .FRAC(30), .CLAMP(0)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .cos_fix(c_cf), .sin_fix(c_sf),
    .cos_neg(c_cn), .sin_neg(c_sn), .out_valid(c_ov), .out_ready(c_or),
    .cos_fp(c_cfp), .sin_fp(c_sfp), .clamped(c_cl));

  // One pair through an otherwise idle pipe; early = out_valid one cycle after transfer.
  task automatic xfer_a(input logic [23:0] c, input logic cn, input logic [23:0] s,
                        input logic sn, output logic early, output logic [65:0] got);
    @(posedge clk); #1;
    a_cf = c; a_cn = cn; a_sf = s; a_sn = sn; a_iv = 1'b1;
    @(posedge clk); #1;
    a_iv = 1'b0;
    @(negedge clk);
    early = a_ov;
    @(negedge clk);
    got = {a_ov, a_cfp, a_sfp, a_cl};
  endtask

  task automatic xfer_b(input logic [23:0] c, input logic cn, input logic [23:0] s,
                        input logic sn, output logic [65:0] got);
    @(posedge clk); #1;
    b_cf = c; b_cn = cn; b_sf = s; b_sn = sn; b_iv = 1'b1;
    @(posedge clk); #1;
    b_iv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    got = {b_ov, b_cfp, b_sfp, b_cl};
  endtask

  task automatic xfer_c(input logic [31:0] c, input logic cn, input logic [31:0] s,
                        input logic sn, output logic [65:0] got);
    @(posedge clk); #1;
    c_cf = c; c_cn = cn; c_sf = s; c_sn = sn; c_iv = 1'b1;
    @(posedge clk); #1;
    c_iv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    got = {c_ov, c_cfp, c_sfp, c_cl};
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({a_ov, a_cfp, a_sfp, a_cl, a_ir} !== {1'b0, 64'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_a got %h exp %h", {a_ov, a_cfp, a_sfp, a_cl, a_ir}, {1'b0, 64'h0, 1'b0, 1'b1});
    end
    checks++;
    if ({b_ov, c_ov, b_ir, c_ir} !== 4'b0011) begin
      errors++;
      $display("FAIL reset_bc got %b exp 0011", {b_ov, c_ov, b_ir, c_ir});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic early;
    logic [65:0] got;
    xfer_a(24'h400000, 1'b0, 24'h200000, 1'b1, early, got);
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency got out_valid=%b exp 0", early);
    end
    checks++;
    if (got !== {1'b1, 32'h3F800000, 32'hBF000000, 1'b0}) begin
      errors++;
      $display("FAIL basic got %h exp %h", got, {1'b1, 32'h3F800000, 32'hBF000000, 1'b0});
    end
  endtask

  task automatic test_sign();
    logic early;
    logic [65:0] got;
    xfer_a(24'h000001, 1'b0, 24'hE00000, 1'b1, early, got);
    checks++;
    if (got !== {1'b1, 32'h34800000, 32'h3F000000, 1'b0}) begin
      errors++;
      $display("FAIL sign_lsb_neg got %h exp %h", got, {1'b1, 32'h34800000, 32'h3F000000, 1'b0});
    end
    xfer_a(24'h000000, 1'b1, 24'h000001, 1'b1, early, got);
    checks++;
    if (got !== {1'b1, 32'h00000000, 32'hB4800000, 1'b0}) begin
      errors++;
      $display("FAIL sign_zero got %h exp %h", got, {1'b1, 32'h00000000, 32'hB4800000, 1'b0});
    end
  endtask

  task automatic test_clamp();
    logic early;
    logic [65:0] got;
    xfer_a(24'h400010, 1'b0, 24'h400000, 1'b0, early, got);
    checks++;
    if (got !== {1'b1, 32'h3F800000, 32'h3F800000, 1'b1}) begin
      errors++;
      $display("FAIL clamp_cos got %h exp %h", got, {1'b1, 32'h3F800000, 32'h3F800000, 1'b1});
    end
    xfer_a(24'h000000, 1'b0, 24'hBFFFF0, 1'b0, early, got);
    checks++;
    if (got !== {1'b1, 32'h00000000, 32'hBF800000, 1'b1}) begin
      errors++;
      $display("FAIL clamp_sin got %h exp %h", got, {1'b1, 32'h00000000, 32'hBF800000, 1'b1});
    end
    xfer_a(24'h800000, 1'b0, 24'h400000, 1'b1, early, got);
    checks++;
    if (got !== {1'b1, 32'hBF800000, 32'hBF800000, 1'b1}) begin
      errors++;
      $display("FAIL clamp_minfs got %h exp %h", got, {1'b1, 32'hBF800000, 32'hBF800000, 1'b1});
    end
  endtask

  task automatic test_noclamp();
    logic [65:0] got;
    xfer_b(24'h400010, 1'b0, 24'h800000, 1'b0, got);
    checks++;
    if (got !== {1'b1, 32'h3F800020, 32'hC0000000, 1'b0}) begin
      errors++;
      $display("FAIL noclamp got %h exp %h", got, {1'b1, 32'h3F800020, 32'hC0000000, 1'b0});
    end
  endtask

  task automatic test_rounding();
    logic [65:0] got;
    xfer_c(32'h40000001, 1'b0, 32'h7FFFFFFF, 1'b0, got);
    checks++;
    if (got !== {1'b1, 32'h3F800000, 32'h40000000, 1'b0}) begin
      errors++;
      $display("FAIL round_carry got %h exp %h", got, {1'b1, 32'h3F800000, 32'h40000000, 1'b0});
    end
    // 0x60 is 0.75 ulp (rounds up); 0x40 is an exact tie with an even lsb (stays).
    xfer_c(32'h40000060, 1'b0, 32'h40000040, 1'b1, got);
    checks++;
    if (got !== {1'b1, 32'h3F800001, 32'hBF800000, 1'b0}) begin
      errors++;
      $display("FAIL round_guard got %h exp %h", got, {1'b1, 32'h3F800001, 32'hBF800000, 1'b0});
    end
    xfer_c(32'h400000C0, 1'b0, 32'h00000000, 1'b0, got);
    checks++;
    if (got !== {1'b1, 32'h3F800002, 32'h00000000, 1'b0}) begin
      errors++;
      $display("FAIL round_tie_odd got %h exp %h", got, {1'b1, 32'h3F800002, 32'h00000000, 1'b0});
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] in_c[4];
    logic [31:0] exp_c[4];
    logic [31:0] exp_s[4];
    int   idx, nout, first, last;
    logic acc;
    in_c  = '{24'h400000, 24'h200000, 24'h100000, 24'h080000};
    exp_c = '{32'h3F800000, 32'h3F000000, 32'h3E800000, 32'h3E000000};
    exp_s = '{32'hBF800000, 32'hBF000000, 32'hBE800000, 32'hBE000000};
    @(posedge clk); #1;
    a_or = 1'b0; idx = 0; a_iv = 1'b1;
    a_cf = in_c[0]; a_sf = in_c[0]; a_cn = 1'b0; a_sn = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      acc = a_iv & a_ir;
      if (cyc >= 3) begin
        checks++;
        if ({a_ov, a_cfp, a_sfp} !== {1'b1, exp_c[0], exp_s[0]}) begin
          errors++;
          $display("FAIL bp_hold got %h exp %h", {a_ov, a_cfp, a_sfp}, {1'b1, exp_c[0], exp_s[0]});
        end
      end
      @(posedge clk); #1;
      if (acc) idx++;
      if (idx < 4) begin a_cf = in_c[idx]; a_sf = in_c[idx]; end
      else a_iv = 1'b0;
    end
    checks++;
    if (idx !== 2 || a_ir !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept got accepted=%0d in_ready=%b exp accepted=2 in_ready=0", idx, a_ir);
    end
    a_or = 1'b1; nout = 0; first = 0; last = 0;
    for (int cyc = 0; cyc < 20 && nout < 4; cyc++) begin
      @(negedge clk);
      acc = a_iv & a_ir;
      if (a_ov) begin
        checks++;
        if ({a_cfp, a_sfp} !== {exp_c[nout], exp_s[nout]}) begin
          errors++;
          $display("FAIL bp_order idx %0d got %h exp %h", nout, {a_cfp, a_sfp}, {exp_c[nout], exp_s[nout]});
        end
        if (nout == 0) first = cyc;
        last = cyc;
        nout++;
      end
      @(posedge clk); #1;
      if (acc) idx++;
      if (idx < 4) begin a_cf = in_c[idx]; a_sf = in_c[idx]; end
      else a_iv = 1'b0;
    end
    checks++;
    if (nout !== 4 || last - first !== 3) begin
      errors++;
      $display("FAIL bp_drain got count=%0d span=%0d exp count=4 span=3", nout, last - first);
    end
    @(negedge clk);
    checks++;
    if (a_ov !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_dup got out_valid=%b exp 0", a_ov);
    end
  endtask

  task automatic test_reset_midop();
    logic early;
    logic [65:0] got;
    @(posedge clk); #1;
    a_or = 1'b0; a_iv = 1'b1;
    a_cf = 24'h400010; a_cn = 1'b0; a_sf = 24'h000000; a_sn = 1'b0;
    @(posedge clk); #1;
    a_cf = 24'h200000;
    @(posedge clk); #1;
    a_iv = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_ov, a_cfp, a_cl, a_ir} !== {1'b1, 32'h3F800000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL midop_pre got %h exp %h", {a_ov, a_cfp, a_cl, a_ir}, {1'b1, 32'h3F800000, 1'b1, 1'b0});
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({a_ov, a_cfp, a_sfp, a_cl, a_ir} !== {1'b0, 64'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL midop_reset got %h exp %h", {a_ov, a_cfp, a_sfp, a_cl, a_ir}, {1'b0, 64'h0, 1'b0, 1'b1});
    end
    @(negedge clk);
    rst = 1'b1;
    a_or = 1'b1;
    xfer_a(24'h200000, 1'b0, 24'h000000, 1'b0, early, got);
    checks++;
    if (early !== 1'b0 || got !== {1'b1, 32'h3F000000, 32'h00000000, 1'b0}) begin
      errors++;
      $display("FAIL midop_after got early=%b %h exp early=0 %h", early, got, {1'b1, 32'h3F000000, 32'h00000000, 1'b0});
    end
  endtask

  initial begin
    rst = 1'b0;
    a_iv = 1'b0; a_cn = 1'b0; a_sn = 1'b0; a_or = 1'b1; a_cf = '0; a_sf = '0;
    b_iv = 1'b0; b_cn = 1'b0; b_sn = 1'b0; b_or = 1'b1; b_cf = '0; b_sf = '0;
    c_iv = 1'b0; c_cn = 1'b0; c_sn = 1'b0; c_or = 1'b1; c_cf = '0; c_sf = '0;
    test_reset();
    test_basic();
    test_sign();
    test_clamp();
    test_noclamp();
    test_rounding();
    test_backpressure();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
